// File: rtl/seq_pkg.sv
// Shared types and instruction layout for the sequence controller.
// Word layout, LSB first: channels, duration, wait_trig.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PREFETCH  = 3'd1,
      S_ARMED     = 3'd2,
      S_RUN       = 3'd3,
      S_WAIT_TRIG = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   localparam int CH_LSB       = 0;
   localparam int MIN_DURATION = 2;

   function automatic int dur_lsb(input int ch_w);
      return ch_w;
   endfunction

   function automatic int wt_bit(input int ch_w, input int dur_w);
      return ch_w + dur_w;
   endfunction

endpackage

// File: rtl/trig_sync.sv
// Trigger synchronizer: two metastability flops, then a registered
// rising-edge detector. Ports: aclk, aresetn, trig_in -> trig_edge.
module trig_sync (
   input  logic aclk,
   input  logic aresetn,
   input  logic trig_in,
   output logic trig_edge
);

   logic s1, s2, s3;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         trig_edge <= 1'b0;
      end else begin
         s1        <= trig_in;
         s2        <= s1;
         s3        <= s2;
         trig_edge <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/sequence_controller.sv
// Plays a program of timed channel words read from an instruction memory.
// Ports: aclk/aresetn, arm/abort/sw_start/trig_in control, num_instr,
// mem_en/mem_addr/mem_rdata memory port, channels/enable/run_monitor/done.
module sequence_controller
   import seq_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CH_W   = 64,
   parameter int DUR_W  = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      arm,
   input  logic                      abort,
   input  logic                      sw_start,
   input  logic                      trig_in,
   input  logic [ADDR_W:0]           num_instr,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [DUR_W+CH_W:0]       mem_rdata,
   output logic [CH_W-1:0]           channels,
   output logic                      enable,
   output logic                      run_monitor,
   output logic                      done
);

   localparam int IW = 1 + DUR_W + CH_W;
   localparam int DL = dur_lsb(CH_W);
   localparam int WT = wt_bit(CH_W, DUR_W);

   state_t            state;
   logic [IW-1:0]     pre, nxt;
   logic              rd_valid;
   logic [ADDR_W:0]   num_q, idx, nidx, fidx;
   logic [DUR_W-1:0]  cnt, hold, ndur;
   logic              trig_edge, go, expire, last, load;

   trig_sync u_sync (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .trig_in   (trig_in),
      .trig_edge (trig_edge)
   );

   // Read data is used directly in the cycle it arrives, else the copy.
   assign nxt    = rd_valid ? mem_rdata : pre;
   assign ndur   = nxt[DL +: DUR_W];
   assign hold   = (ndur < DUR_W'(MIN_DURATION)) ?
                   DUR_W'(MIN_DURATION - 1) : ndur - 1'b1;
   assign go     = trig_edge | sw_start;
   assign expire = (cnt == '0);
   assign last   = (idx == num_q - 1'b1);
   assign nidx   = (state == S_ARMED) ? '0 : idx + 1'b1;
   assign fidx   = nidx + 1'b1;

   // The wait_trig bit of instruction 0 is never consulted: ARMED
   // always needs a start event anyway.
   always_comb begin
      load = 1'b0;
      case (state)
         S_ARMED, S_WAIT_TRIG: load = go;
         S_RUN:   load = expire && !last && !nxt[WT];
         default: load = 1'b0;
      endcase
   end

   assign enable      = (state == S_RUN) || (state == S_WAIT_TRIG);
   assign run_monitor = (state == S_PREFETCH) || (state == S_ARMED) ||
                        enable;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= S_IDLE;
         pre      <= '0;
         rd_valid <= 1'b0;
         num_q    <= '0;
         idx      <= '0;
         cnt      <= '0;
         channels <= '0;
         done     <= 1'b0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_en   <= 1'b0;
         rd_valid <= mem_en;
         if (rd_valid) pre <= mem_rdata;
         if (state == S_RUN && !expire) cnt <= cnt - 1'b1;

         if (abort) begin
            state    <= S_IDLE;
            channels <= '0;
         end else if (load) begin
            state    <= S_RUN;
            channels <= nxt[CH_LSB +: CH_W];
            cnt      <= hold;
            idx      <= nidx;
            // Prefetch the following word; fidx never exceeds 2^ADDR_W.
            if (fidx < num_q) begin
               mem_en   <= 1'b1;
               mem_addr <= fidx[ADDR_W-1:0];
            end
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (arm) begin
                     if (num_instr == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state    <= S_PREFETCH;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                        num_q    <= num_instr;
                        done     <= 1'b0;
                     end
                  end
               end
               S_PREFETCH: state <= S_ARMED;
               S_RUN: begin
                  if (expire) begin
                     if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= S_WAIT_TRIG;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sequence_controller.sv
// Self-checking bench for sequence_controller: scoreboard of expected
// per-cycle {enable, done, channels} plus directed control checks.
module tb_sequence_controller;

   localparam int ADDR_W = 3;
   localparam int CH_W   = 8;
   localparam int DUR_W  = 8;
   localparam int IW     = 1 + DUR_W + CH_W;

   typedef struct packed {
      logic            en;
      logic            dn;
      logic [CH_W-1:0] ch;
   } exp_t;

   logic aclk = 0, aresetn = 0, arm = 0, abort = 0;
   logic sw_start = 0, trig_in = 0;
   logic [ADDR_W:0]   num_instr = '0;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [IW-1:0]     mem_rdata;
   logic [CH_W-1:0]   channels;
   logic              enable, run_monitor, done;

   logic [IW-1:0] rom [8];
   exp_t sb[$];
   int errors = 0, checks = 0, rd_cnt = 0;

   sequence_controller #(
      .ADDR_W (ADDR_W),
      .CH_W   (CH_W),
      .DUR_W  (DUR_W)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .arm         (arm),
      .abort       (abort),
      .sw_start    (sw_start),
      .trig_in     (trig_in),
      .num_instr   (num_instr),
      .mem_en      (mem_en),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .channels    (channels),
      .enable      (enable),
      .run_monitor (run_monitor),
      .done        (done)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      if (mem_en) begin
         mem_rdata <= rom[mem_addr];
         rd_cnt    <= rd_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic set_instr(input int i, input logic wt,
                            input int dur, input int ch);
      rom[i] = {wt, DUR_W'(dur), CH_W'(ch)};
   endtask

   // Expected trace for a program with no wait_trig stalls.
   task automatic push_trace(input int n, input int tail);
      exp_t e;
      int d;
      e = '0;
      for (int i = 0; i < n; i++) begin
         d = int'(rom[i][CH_W +: DUR_W]);
         if (d < 2) d = 2;
         e = '{en: 1'b1, dn: 1'b0, ch: rom[i][CH_W-1:0]};
         repeat (d) sb.push_back(e);
      end
      e.en = 1'b0;
      e.dn = 1'b1;
      repeat (tail) sb.push_back(e);
   endtask

   task automatic push_n(input int n, input logic en, input logic dn,
                         input int ch);
      exp_t e;
      e = '{en: en, dn: dn, ch: CH_W'(ch)};
      repeat (n) sb.push_back(e);
   endtask

   task automatic arm_prog(input int n);
      @(negedge aclk);
      arm = 1;
      num_instr = (ADDR_W+1)'(n);
      @(negedge aclk);
      arm = 0;
      @(negedge aclk);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({channels, enable, run_monitor, done, mem_en, mem_addr} !== '0)
         begin
         errors++;
         $display("FAIL reset: ch=%h en=%b rm=%b dn=%b me=%b ma=%h",
                  channels, enable, run_monitor, done, mem_en, mem_addr);
      end
      @(negedge aclk);
      aresetn = 1;
      repeat (2) @(negedge aclk);
   endtask

   task automatic test_zero_len();
      int rd0;
      rd0 = rd_cnt;
      arm_prog(0);
      repeat (2) @(negedge aclk);
      checks++;
      if ({done, run_monitor, enable} !== 3'b100 || rd_cnt !== rd0) begin
         errors++;
         $display("FAIL zero_len: dn=%b rm=%b en=%b reads=%0d want 1/0/0/0",
                  done, run_monitor, enable, rd_cnt - rd0);
      end
   endtask

   task automatic test_basic();
      exp_t e;
      int rd0, k;
      set_instr(0, 0, 5, 8'h01);
      set_instr(1, 0, 3, 8'h02);
      set_instr(2, 0, 2, 8'h03);
      rd0 = rd_cnt;
      arm_prog(3);
      checks++;
      if ({run_monitor, enable, done} !== 3'b100) begin
         errors++;
         $display("FAIL basic_armed: rm=%b en=%b dn=%b want 1/0/0",
                  run_monitor, enable, done);
      end
      @(negedge aclk);
      sw_start = 1;
      push_trace(3, 3);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge aclk);
         sw_start = 0;
         if (k == 2) trig_in = 1;
         if (k == 5) trig_in = 0;
         k++;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL basic cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
      checks++;
      if (run_monitor !== 1'b0 || rd_cnt - rd0 !== 3) begin
         errors++;
         $display("FAIL basic_end: rm=%b reads=%0d want 0/3",
                  run_monitor, rd_cnt - rd0);
      end
   endtask

   task automatic test_wait_trig();
      exp_t e;
      int k;
      set_instr(0, 0, 3, 8'hA1);
      set_instr(1, 1, 2, 8'hB2);
      arm_prog(2);
      @(negedge aclk);
      sw_start = 1;
      push_n(6, 1, 0, 8'hA1);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge aclk);
         sw_start = 0;
         k++;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL wait_hold cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
      trig_in = 1;
      push_n(3, 1, 0, 8'hA1);
      push_n(2, 1, 0, 8'hB2);
      push_n(2, 0, 1, 8'hB2);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge aclk);
         k++;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL wait_trig cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
      trig_in = 0;
      repeat (3) @(negedge aclk);
   endtask

   task automatic test_short_dur();
      exp_t e;
      int k;
      set_instr(0, 0, 0, 8'h11);
      set_instr(1, 0, 1, 8'h22);
      set_instr(2, 0, 0, 8'h33);
      set_instr(3, 0, 1, 8'h44);
      arm_prog(4);
      @(negedge aclk);
      sw_start = 1;
      push_trace(4, 2);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge aclk);
         sw_start = 0;
         k++;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL short_dur cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
   endtask

   task automatic test_abort();
      exp_t e;
      int k;
      set_instr(0, 0, 5, 8'h01);
      set_instr(1, 0, 3, 8'h02);
      set_instr(2, 0, 2, 8'h03);
      @(negedge aclk);
      arm = 1;
      num_instr = 4'd3;
      @(negedge aclk);
      arm = 0;
      checks++;
      if ({mem_en, mem_addr, done, run_monitor} !== {1'b1, 3'd0, 1'b0, 1'b1})
         begin
         errors++;
         $display("FAIL abort_prefetch: me=%b ma=%0d dn=%b rm=%b want 1/0/0/1",
                  mem_en, mem_addr, done, run_monitor);
      end
      @(negedge aclk);
      sw_start = 1;
      push_trace(3, 0);
      for (k = 1; k <= 7; k++) begin
         @(negedge aclk);
         sw_start = 0;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL abort_run cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
      sb.delete();
      abort = 1;
      arm = 1;
      @(negedge aclk);
      abort = 0;
      arm = 0;
      repeat (2) @(negedge aclk);
      checks++;
      if ({channels, enable, run_monitor, done} !== '0) begin
         errors++;
         $display("FAIL abort_idle: ch=%h en=%b rm=%b dn=%b want all 0",
                  channels, enable, run_monitor, done);
      end
      @(negedge aclk);
      arm = 1;
      @(negedge aclk);
      arm = 0;
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL abort_rearm: me=%b ma=%0d want 1/0",
                  mem_en, mem_addr);
      end
      @(negedge aclk);
      sw_start = 1;
      push_trace(3, 1);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge aclk);
         sw_start = 0;
         k++;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL abort_replay cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
      abort = 1;
      @(negedge aclk);
      abort = 0;
      checks++;
      if ({done, run_monitor, channels} !== {1'b1, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL abort_done: dn=%b rm=%b ch=%h want 1/0/00",
                  done, run_monitor, channels);
      end
   endtask

   task automatic test_full_depth();
      exp_t e;
      int rd0, k;
      for (int i = 0; i < 8; i++) set_instr(i, 0, 2 + (i % 2), 16 * i + 1);
      rd0 = rd_cnt;
      arm_prog(8);
      @(negedge aclk);
      sw_start = 1;
      push_trace(8, 2);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge aclk);
         sw_start = 0;
         k++;
         e = sb.pop_front();
         checks++;
         if ({enable, done, channels} !== e) begin
            errors++;
            $display("FAIL full_depth cyc%0d: got en=%b dn=%b ch=%h want %b %b %h",
                     k, enable, done, channels, e.en, e.dn, e.ch);
         end
      end
      checks++;
      if (rd_cnt - rd0 !== 8) begin
         errors++;
         $display("FAIL full_reads: got %0d want 8", rd_cnt - rd0);
      end
   endtask

   task automatic test_async_reset();
      set_instr(0, 0, 6, 8'h5A);
      set_instr(1, 0, 6, 8'hA5);
      arm_prog(2);
      @(negedge aclk);
      sw_start = 1;
      @(negedge aclk);
      sw_start = 0;
      repeat (3) @(negedge aclk);
      #2 aresetn = 0;
      #1;
      checks++;
      if ({channels, enable, run_monitor, done, mem_en} !== '0) begin
         errors++;
         $display("FAIL async_reset: ch=%h en=%b rm=%b dn=%b me=%b want 0",
                  channels, enable, run_monitor, done, mem_en);
      end
      @(negedge aclk);
      aresetn = 1;
      @(negedge aclk);
      sw_start = 1;
      @(negedge aclk);
      sw_start = 0;
      repeat (2) @(negedge aclk);
      checks++;
      if ({channels, enable, run_monitor} !== '0) begin
         errors++;
         $display("FAIL post_reset: ch=%h en=%b rm=%b want idle",
                  channels, enable, run_monitor);
      end
   endtask

   initial begin
      test_reset();
      test_zero_len();
      test_basic();
      test_wait_trig();
      test_short_dur();
      test_abort();
      test_full_depth();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
